// File: rtl/buffer_write_controller_ifmap.sv
// Streams a row-major IFMap region from memory into a FIFO,
// tagging each word with start/end-of-row flags.
module buffer_write_controller_ifmap #(
  parameter int DATA_WIDTH = 3,
  parameter int ADDR_WIDTH = 4,
  parameter int LEN_WIDTH  = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_WIDTH-1:0]  row_len,
  input  logic [LEN_WIDTH-1:0]  num_rows,
  output logic                  mem_ren,
  output logic [ADDR_WIDTH-1:0] mem_raddr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  ready,
  output logic                  wen_buf,
  output logic [DATA_WIDTH+1:0] buf_din,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    PUSH,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [ADDR_WIDTH-1:0] addr, addr_nx;
  logic [LEN_WIDTH-1:0]  col, col_nx;
  logic [LEN_WIDTH-1:0]  row, row_nx;
  logic [LEN_WIDTH-1:0]  len_q, len_nx;
  logic [LEN_WIDTH-1:0]  rows_q, rows_nx;
  logic                  col_last;
  logic                  row_last;

  assign col_last = (col == len_q - LEN_WIDTH'(1));
  assign row_last = (row == rows_q - LEN_WIDTH'(1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      addr   <= '0;
      col    <= '0;
      row    <= '0;
      len_q  <= '0;
      rows_q <= '0;
    end else begin
      state  <= state_nx;
      addr   <= addr_nx;
      col    <= col_nx;
      row    <= row_nx;
      len_q  <= len_nx;
      rows_q <= rows_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    addr_nx   = addr;
    col_nx    = col;
    row_nx    = row;
    len_nx    = len_q;
    rows_nx   = rows_q;
    mem_ren   = 1'b0;
    mem_raddr = addr;
    wen_buf   = 1'b0;
    buf_din   = '0;
    busy      = 1'b0;
    done      = 1'b0;

    unique case (state)
      IDLE: begin
        mem_raddr = '0;
        if (init && !clr) begin
          addr_nx = base_addr;
          len_nx  = row_len;
          rows_nx = num_rows;
          col_nx  = '0;
          row_nx  = '0;
          if (row_len == '0 || num_rows == '0)
            state_nx = DONE;
          else
            state_nx = READ;
        end
      end
      READ: begin
        busy     = 1'b1;
        mem_ren  = 1'b1;
        state_nx = PUSH;
      end
      PUSH: begin
        busy    = 1'b1;
        buf_din = {col == '0, col_last, mem_rdata};
        wen_buf = ready;
        if (ready) begin
          if (col_last && row_last) begin
            state_nx = DONE;
          end else begin
            // prefetch next word so one word is pushed per cycle
            addr_nx   = addr + ADDR_WIDTH'(1);
            mem_ren   = 1'b1;
            mem_raddr = addr_nx;
            if (col_last) begin
              col_nx = '0;
              row_nx = row + LEN_WIDTH'(1);
            end else begin
              col_nx = col + LEN_WIDTH'(1);
            end
          end
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
    endcase

    if (clr) begin
      state_nx = IDLE;
      wen_buf  = 1'b0;
      mem_ren  = 1'b0;
      done     = 1'b0;
    end
  end

endmodule
